// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, port identifiers and
// the one-deep request slot record used by both the CPU and PPU sides.
package sdram_arb_pkg;

    // Byte address width of the mapper bus. The request slot storage is sized
    // from this constant, so the arbiter's ADDR_W must stay equal to it.
    localparam int ADDR_W_DEF = 25;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

    // Port ids double as indices into the per-port arrays in the top.
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_PPU = 1'b1
    } port_id_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  wr;
        logic [7:0]            wdata;
    } slot_t;

    // The port that should win a contention when `last` won the previous one.
    function automatic port_id_t other_port(input port_id_t last);
        return (last == PORT_CPU) ? PORT_PPU : PORT_CPU;
    endfunction

endpackage

// File: rtl/sdram_req_slot.sv
// One-deep request slot for a single mapper port. Captures a request strobe,
// lets a newer strobe replace a not-yet-issued request (flagging overflow),
// and releases the entry when the arbiter issues it.
module sdram_req_slot
    import sdram_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_W_DEF-1:0] addr,
    input  logic                  wr,
    input  logic [7:0]            wdata,
    input  logic                  issue,
    output logic                  slot_valid,
    output logic [ADDR_W_DEF-1:0] slot_addr,
    output logic                  slot_wr,
    output logic [7:0]            slot_wdata,
    output logic                  overflow
);

    slot_t slot_reg;
    logic  overflow_reg;

    // Capture / overwrite / release. When issue is high the arbiter took
    // either the stored entry or (if the slot was empty) the incoming strobe
    // directly, so a strobe only needs storing if an older entry left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg     <= '0;
            overflow_reg <= 1'b0;
        end else if (issue) begin
            if (req && slot_reg.valid) begin
                slot_reg <= '{valid: 1'b1, addr: addr, wr: wr, wdata: wdata};
            end else begin
                slot_reg.valid <= 1'b0;
            end
        end else if (req) begin
            if (slot_reg.valid) begin
                overflow_reg <= 1'b1;
            end
            slot_reg <= '{valid: 1'b1, addr: addr, wr: wr, wdata: wdata};
        end
    end

    assign slot_valid = slot_reg.valid;
    assign slot_addr  = slot_reg.addr;
    assign slot_wr    = slot_reg.wr;
    assign slot_wdata = slot_reg.wdata;
    assign overflow   = overflow_reg;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Merges the CPU and PPU translated access streams onto the SDRAM
// controller's single request/acknowledge port. Each port has a one-deep
// slot; contention is resolved round-robin; read data returns to per-port
// holding registers.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int   ADDR_W    = ADDR_W_DEF,
    parameter logic PPU_FIRST = 1'b1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_done,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic              ppu_wr,
    input  logic [7:0]        ppu_wdata,
    output logic [7:0]        ppu_rdata,
    output logic              ppu_done,
    output logic              sd_req,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_wr,
    output logic [7:0]        sd_wdata,
    input  logic              sd_ack,
    input  logic              sd_rvalid,
    input  logic [7:0]        sd_rdata,
    output logic              busy,
    output logic [1:0]        overflow
);

    // Per-port views, indexed by port_id_t.
    slot_t      port_in   [2];
    slot_t      port_pick [2];
    logic [1:0] port_cand;
    logic [1:0] port_issue;
    logic [1:0] port_ovf;

    // FSM and registered outputs.
    arb_state_t        state_reg;
    port_id_t          owner_reg;
    port_id_t          last_grant_reg;
    logic              sd_req_reg;
    logic [ADDR_W-1:0] sd_addr_reg;
    logic              sd_wr_reg;
    logic [7:0]        sd_wdata_reg;
    logic [1:0]        done_reg;
    logic [1:0][7:0]   rdata_reg;

    // Arbitration terms.
    logic     issue_now;
    logic     contention;
    port_id_t grant_port;

    assign port_in[PORT_CPU] = '{valid: cpu_req, addr: cpu_addr, wr: cpu_wr, wdata: cpu_wdata};
    assign port_in[PORT_PPU] = '{valid: ppu_req, addr: ppu_addr, wr: ppu_wr, wdata: ppu_wdata};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic                  slot_valid;
            logic [ADDR_W_DEF-1:0] slot_addr;
            logic                  slot_wr;
            logic [7:0]            slot_wdata;

            sdram_req_slot u_slot (
                .clk        (sysclk),
                .rst_n      (reset),
                .req        (port_in[gi].valid),
                .addr       (port_in[gi].addr),
                .wr         (port_in[gi].wr),
                .wdata      (port_in[gi].wdata),
                .issue      (port_issue[gi]),
                .slot_valid (slot_valid),
                .slot_addr  (slot_addr),
                .slot_wr    (slot_wr),
                .slot_wdata (slot_wdata),
                .overflow   (port_ovf[gi])
            );

            // The stored entry is older than any same-cycle strobe, so it
            // goes first; an empty slot lets the strobe bypass straight in.
            assign port_pick[gi] = slot_valid
                ? '{valid: 1'b1, addr: slot_addr, wr: slot_wr, wdata: slot_wdata}
                : port_in[gi];
            assign port_cand[gi] = port_pick[gi].valid;
        end
    endgenerate

    // Round-robin only matters under contention; a lone candidate always wins.
    assign contention = &port_cand;
    assign grant_port = contention ? other_port(last_grant_reg)
                      : (port_cand[PORT_PPU] ? PORT_PPU : PORT_CPU);
    assign issue_now  = (state_reg == IDLE) && (|port_cand);
    assign port_issue = {issue_now && (grant_port == PORT_PPU),
                         issue_now && (grant_port == PORT_CPU)};

    // Transaction FSM: grant, hold the request until ack, collect read data.
    // last_grant records contention winners only, so back-to-back contended
    // pairs alternate which port goes first.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            owner_reg      <= PORT_CPU;
            last_grant_reg <= PPU_FIRST ? PORT_CPU : PORT_PPU;
            sd_req_reg     <= 1'b0;
            sd_addr_reg    <= '0;
            sd_wr_reg      <= 1'b0;
            sd_wdata_reg   <= '0;
            done_reg       <= '0;
            rdata_reg      <= '0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (issue_now) begin
                        sd_req_reg   <= 1'b1;
                        sd_addr_reg  <= port_pick[grant_port].addr;
                        sd_wr_reg    <= port_pick[grant_port].wr;
                        sd_wdata_reg <= port_pick[grant_port].wdata;
                        owner_reg    <= grant_port;
                        if (contention) begin
                            last_grant_reg <= grant_port;
                        end
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd_ack) begin
                        sd_req_reg <= 1'b0;
                        if (sd_wr_reg) begin
                            done_reg[owner_reg] <= 1'b1;
                            state_reg           <= IDLE;
                        end else begin
                            state_reg <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (sd_rvalid) begin
                        rdata_reg[owner_reg] <= sd_rdata;
                        done_reg[owner_reg]  <= 1'b1;
                        state_reg            <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sd_req    = sd_req_reg;
    assign sd_addr   = sd_addr_reg;
    assign sd_wr     = sd_wr_reg;
    assign sd_wdata  = sd_wdata_reg;
    assign cpu_done  = done_reg[PORT_CPU];
    assign ppu_done  = done_reg[PORT_PPU];
    assign cpu_rdata = rdata_reg[PORT_CPU];
    assign ppu_rdata = rdata_reg[PORT_PPU];
    assign busy      = (state_reg != IDLE);
    assign overflow  = port_ovf;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed, table-driven bench for sdram_port_arbiter. Each table row is one
// clock cycle: the inputs driven in that cycle and the outputs expected to be
// visible during it. Reset corner cases follow as hand-written sequences.
module tb_sdram_port_arbiter;

    localparam int AW = 25;

    logic          sysclk = 1'b0;
    logic          reset  = 1'b0;
    logic          cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          ppu_req = 1'b0, ppu_wr = 1'b0;
    logic [AW-1:0] ppu_addr = '0;
    logic [7:0]    ppu_wdata = '0;
    logic          sd_ack = 1'b0, sd_rvalid = 1'b0;
    logic [7:0]    sd_rdata = '0;
    logic [7:0]    cpu_rdata, ppu_rdata, sd_wdata;
    logic          cpu_done, ppu_done, sd_req, sd_wr, busy;
    logic [AW-1:0] sd_addr;
    logic [1:0]    overflow;

    int errors = 0;
    int checks = 0;

    sdram_port_arbiter #(.ADDR_W(AW), .PPU_FIRST(1'b1)) dut (
        .sysclk(sysclk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_wr(ppu_wr), .ppu_wdata(ppu_wdata),
        .ppu_rdata(ppu_rdata), .ppu_done(ppu_done),
        .sd_req(sd_req), .sd_addr(sd_addr), .sd_wr(sd_wr), .sd_wdata(sd_wdata),
        .sd_ack(sd_ack), .sd_rvalid(sd_rvalid), .sd_rdata(sd_rdata),
        .busy(busy), .overflow(overflow)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic          cr;  logic [AW-1:0] ca; logic cw; logic [7:0] cd;
        logic          pr;  logic [AW-1:0] pa; logic pw; logic [7:0] pd;
        logic          ack; logic rv; logic [7:0] rd;
        logic          e_req; logic [AW-1:0] e_addr; logic e_wr; logic [7:0] e_wd;
        logic          e_cdone; logic e_pdone; logic e_busy;
        logic [7:0]    e_crd; logic [7:0] e_prd; logic [1:0] e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void chk(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endfunction

    task automatic row(
        input logic cr, input logic [AW-1:0] ca, input logic cw, input logic [7:0] cd,
        input logic pr, input logic [AW-1:0] pa, input logic pw, input logic [7:0] pd,
        input logic ack, input logic rv, input logic [7:0] rd,
        input logic e_req, input logic [AW-1:0] e_addr, input logic e_wr, input logic [7:0] e_wd,
        input logic e_cdone, input logic e_pdone, input logic e_busy,
        input logic [7:0] e_crd, input logic [7:0] e_prd, input logic [1:0] e_ovf);
        vec_t v;
        v = '{cr, ca, cw, cd, pr, pa, pw, pd, ack, rv, rd,
              e_req, e_addr, e_wr, e_wd, e_cdone, e_pdone, e_busy, e_crd, e_prd, e_ovf};
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_addr = '0; cpu_wr = 0; cpu_wdata = '0;
        ppu_req = 0; ppu_addr = '0; ppu_wr = 0; ppu_wdata = '0;
        sd_ack = 0; sd_rvalid = 0; sd_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        //   cr ca          cw cd     pr pa           pw pd     ack rv rd     req addr        wr wd     cdn pdn bsy crd    prd    ovf
        // CPU read 0x8000 alone, ack immediately, rvalid three cycles later
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'h00, 'h00, 2'b00); // 0
        row(1, 'h8000,    0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'h00, 'h00, 2'b00); // 1
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h8000,    0, 'h00,  0, 0, 1, 'h00, 'h00, 2'b00); // 2
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 1, 'h00, 'h00, 2'b00); // 3
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 1, 'h00, 'h00, 2'b00); // 4
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 1, 'hA5,   0, 'h0,       0, 'h00,  0, 0, 1, 'h00, 'h00, 2'b00); // 5
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  1, 0, 0, 'hA5, 'h00, 2'b00); // 6
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'hA5, 'h00, 2'b00); // 7
        // Simultaneous writes: PPU wins the first contention, then CPU
        row(1, 'h111,     1, 'h11,  1, 'h222,     1, 'h22,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'hA5, 'h00, 2'b00); // 8
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h222,     1, 'h22,  0, 0, 1, 'hA5, 'h00, 2'b00); // 9
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 1, 0, 'hA5, 'h00, 2'b00); // 10
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h111,     1, 'h11,  0, 0, 1, 'hA5, 'h00, 2'b00); // 11
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  1, 0, 0, 'hA5, 'h00, 2'b00); // 12
        // Second simultaneous pair: CPU goes first this time
        row(1, 'h333,     1, 'h33,  1, 'h444,     1, 'h44,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'hA5, 'h00, 2'b00); // 13
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h333,     1, 'h33,  0, 0, 1, 'hA5, 'h00, 2'b00); // 14
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  1, 0, 0, 'hA5, 'h00, 2'b00); // 15
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h444,     1, 'h44,  0, 0, 1, 'hA5, 'h00, 2'b00); // 16
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 1, 0, 'hA5, 'h00, 2'b00); // 17
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'hA5, 'h00, 2'b00); // 18
        // PPU read in flight; two CPU strobes, only the second survives
        row(0, 'h0,       0, 'h00,  1, 'h2000,    0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'hA5, 'h00, 2'b00); // 19
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h2000,    0, 'h00,  0, 0, 1, 'hA5, 'h00, 2'b00); // 20
        row(1, 'h10,      0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 1, 'hA5, 'h00, 2'b00); // 21
        row(1, 'h20,      0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 1, 'hA5, 'h00, 2'b00); // 22
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 1, 'h5A,   0, 'h0,       0, 'h00,  0, 0, 1, 'hA5, 'h00, 2'b01); // 23
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 1, 0, 'hA5, 'h5A, 2'b01); // 24
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h20,      0, 'h00,  0, 0, 1, 'hA5, 'h5A, 2'b01); // 25
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 1, 'hA5, 'h5A, 2'b01); // 26
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 1, 'h77,   0, 'h0,       0, 'h00,  0, 0, 1, 'hA5, 'h5A, 2'b01); // 27
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  1, 0, 0, 'h77, 'h5A, 2'b01); // 28
        // PPU write with ack held off five cycles; fields must stay put
        row(0, 'h0,       0, 'h00,  1, 'h102005,  1, 'h3C,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'h77, 'h5A, 2'b01); // 29
        for (int k = 0; k < 5; k++) begin
            row(0, 'h0,   0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   1, 'h102005,  1, 'h3C,  0, 0, 1, 'h77, 'h5A, 2'b01); // 30-34
        end
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   1, 'h102005,  1, 'h3C,  0, 0, 1, 'h77, 'h5A, 2'b01); // 35
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 1, 0, 'h77, 'h5A, 2'b01); // 36
        // Spurious rvalid and ack while idle are ignored
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 1, 'hFF,   0, 'h0,       0, 'h00,  0, 0, 0, 'h77, 'h5A, 2'b01); // 37
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  1, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'h77, 'h5A, 2'b01); // 38
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'h77, 'h5A, 2'b01); // 39
        row(0, 'h0,       0, 'h00,  0, 'h0,       0, 'h00,  0, 0, 'h00,   0, 'h0,       0, 'h00,  0, 0, 0, 'h77, 'h5A, 2'b01); // 40

        // Reset held for a few cycles, released just after a rising edge.
        clear_inputs();
        repeat (3) @(posedge sysclk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            cpu_req = vecs[i].cr; cpu_addr = vecs[i].ca; cpu_wr = vecs[i].cw; cpu_wdata = vecs[i].cd;
            ppu_req = vecs[i].pr; ppu_addr = vecs[i].pa; ppu_wr = vecs[i].pw; ppu_wdata = vecs[i].pd;
            sd_ack = vecs[i].ack; sd_rvalid = vecs[i].rv; sd_rdata = vecs[i].rd;
            @(negedge sysclk);
            chk("sd_req", i, 32'(sd_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk("sd_addr", i, 32'(sd_addr), 32'(vecs[i].e_addr));
                chk("sd_wr", i, 32'(sd_wr), 32'(vecs[i].e_wr));
                chk("sd_wdata", i, 32'(sd_wdata), 32'(vecs[i].e_wd));
            end
            chk("cpu_done", i, 32'(cpu_done), 32'(vecs[i].e_cdone));
            chk("ppu_done", i, 32'(ppu_done), 32'(vecs[i].e_pdone));
            chk("busy", i, 32'(busy), 32'(vecs[i].e_busy));
            chk("cpu_rdata", i, 32'(cpu_rdata), 32'(vecs[i].e_crd));
            chk("ppu_rdata", i, 32'(ppu_rdata), 32'(vecs[i].e_prd));
            chk("overflow", i, 32'(overflow), 32'(vecs[i].e_ovf));
            $display("cycle %0d: sd_req=%0b sd_addr=0x%0h busy=%0b done=%0b%0b ovf=%0b",
                     i, sd_req, sd_addr, busy, ppu_done, cpu_done, overflow);
        end

        // Reset during WAIT_DATA with the PPU slot holding a request.
        tick();
        clear_inputs();
        cpu_req = 1; cpu_addr = 'h55; cpu_wr = 0;
        tick();
        cpu_req = 0;
        chk("rst_seq_req", 100, 32'(sd_req), 32'd1);
        sd_ack = 1;
        ppu_req = 1; ppu_addr = 'h66; ppu_wr = 1; ppu_wdata = 'h99;
        tick();
        sd_ack = 0; ppu_req = 0;
        chk("rst_seq_wait_busy", 101, 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_req", 102, 32'(sd_req), 32'd0);
        chk("rst_busy", 102, 32'(busy), 32'd0);
        chk("rst_done", 102, 32'({ppu_done, cpu_done}), 32'd0);
        chk("rst_ovf", 102, 32'(overflow), 32'd0);
        chk("rst_cpu_rdata", 102, 32'(cpu_rdata), 32'd0);
        chk("rst_ppu_rdata", 102, 32'(ppu_rdata), 32'd0);
        $display("reset in WAIT_DATA: sd_req=%0b busy=%0b", sd_req, busy);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle_req", 103 + k, 32'(sd_req), 32'd0);
            chk("post_rst_idle_busy", 103 + k, 32'(busy), 32'd0);
        end
        // Fresh request after release.
        cpu_req = 1; cpu_addr = 'h77; cpu_wr = 1; cpu_wdata = 'hEE;
        tick();
        cpu_req = 0;
        chk("fresh_req", 110, 32'(sd_req), 32'd1);
        chk("fresh_addr", 110, 32'(sd_addr), 32'h77);
        chk("fresh_wr", 110, 32'(sd_wr), 32'd1);
        chk("fresh_wdata", 110, 32'(sd_wdata), 32'hEE);
        sd_ack = 1;
        tick();
        sd_ack = 0;
        chk("fresh_cpu_done", 111, 32'(cpu_done), 32'd1);
        chk("fresh_ppu_done", 111, 32'(ppu_done), 32'd0);
        chk("fresh_req_drop", 111, 32'(sd_req), 32'd0);
        tick();
        chk("fresh_done_width", 112, 32'(cpu_done), 32'd0);
        $display("fresh write after reset: addr=0x77 data=0xEE");

        // Reset while a request is being presented drops sd_req at once.
        ppu_req = 1; ppu_addr = 'h88; ppu_wr = 0;
        tick();
        ppu_req = 0;
        chk("issue_rst_pre", 113, 32'(sd_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("issue_rst_req", 114, 32'(sd_req), 32'd0);
        chk("issue_rst_busy", 114, 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("issue_rst_after", 115, 32'(sd_req), 32'd0);
        $display("reset in ISSUE: sd_req=%0b", sd_req);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Sits between the mapper control block and the SDRAM controller. The mapper block produces two independent translated access streams: CPU (PRG/WRAM) and PPU (CHR/CHR-RAM). This block merges them onto the controller's single request/acknowledge port. It captures each port's request in a one-deep slot, arbitrates round-robin when both ports are pending, and tracks the in-flight transaction. Read data is returned into per-port holding registers, which the mapper block's data inputs read.

## Interface
Parameters:
- ADDR_W, 25, SDRAM byte address width (matches mapper bus width)
- PPU_FIRST, 1, port that wins the first contention after reset (1 = PPU, 0 = CPU)

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  one-cycle strobe: new CPU-side access
- cpu_addr  in  ADDR_W  translated CPU address (sdram_cpu_bus)
- cpu_wr  in  1  1 = write
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  last CPU read data, held
- cpu_done  out  1  one-cycle pulse: CPU access completed
- ppu_req, ppu_addr, ppu_wr, ppu_wdata, ppu_rdata, ppu_done: same as CPU set, for the PPU port
- sd_req  out  1  request to controller; held until sd_ack
- sd_addr  out  ADDR_W  request address, stable while sd_req
- sd_wr  out  1  request type
- sd_wdata  out  8  write data
- sd_ack  in  1  controller accepted request (sampled while sd_req=1)
- sd_rvalid  in  1  one-cycle pulse: read data valid
- sd_rdata  in  8  read data
- busy  out  1  state ≠ IDLE
- overflow  out  2  sticky per port: {ppu, cpu} request replaced before issue

## Operation
- Each port has a slot holding {valid, addr, wr, wdata}. A request strobe loads the slot.
  - If the slot is already valid and not yet issued, the new request overwrites it (latest wins) and sets that port's overflow bit.
  - A request in the same cycle the slot is issued fills the freed slot; no overflow.
- FSM: IDLE → ISSUE → (read) WAIT_DATA → IDLE; (write) IDLE after ack.
- IDLE: candidates are valid slots OR same-cycle incoming strobes (bypass).
  - One candidate: grant it.
  - Two candidates: grant the port not granted last. The last_grant reset value derives from PPU_FIRST.
  - On grant: load sd_addr/sd_wr/sd_wdata, set sd_req, clear the slot, go to ISSUE.
- ISSUE: hold sd_req and its fields stable.
  - On sd_ack: drop sd_req.
  - Write: pulse the granted port's done, go to IDLE.
  - Read: go to WAIT_DATA.
- WAIT_DATA: on sd_rvalid, load the granted port's rdata and pulse its done, go to IDLE.
- sd_rvalid outside WAIT_DATA is ignored. sd_ack while sd_req=0 is ignored.
- rdata registers change only on that port's read completion. Writes leave them unchanged.
- overflow clears only on reset.

## Timing
- Reset value: all outputs 0; slots invalid; state IDLE; last_grant = PPU_FIRST ? CPU : PPU.
- Asserting reset mid-transaction drops sd_req immediately. The controller tolerates the abandoned access.
- Strobe in cycle N with the FSM idle: sd_req high in N+1.
- Write, ack in N+1: done pulse in N+2; next grant possible from N+2, sd_req again in N+3.
- Read, ack in cycle A, rvalid in cycle R > A: rdata updated and done high in R+1.
- Fastest read: R = A+1.
- Worst-case wait for a pending port is one full transaction of the other port.
- done is exactly one cycle; never both ports' done in the same cycle.

## Structure
- Package sdram_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT_DATA}
  - port id enum {PORT_CPU, PORT_PPU}
  - ADDR_W default constant
  - slot struct {valid, addr, wr, wdata}
- Sub-module sdram_req_slot, instantiated twice (CPU, PPU).
  - Contains capture, overwrite/overflow logic and the issue-clear handshake.
- Arbitration, FSM and return routing live in the top.

## Test plan
- CPU read 0x0008000 alone, controller acks in 1 cycle, rvalid 3 cycles later with 0xA5 → sd_req high 1 cycle after the strobe; cpu_rdata=0xA5 and cpu_done one cycle after rvalid; ppu_done never pulses.
- cpu_req and ppu_req in the same cycle after reset, PPU_FIRST=1 → PPU issued first, CPU issued immediately after; a second simultaneous pair issues CPU first (round-robin alternates).
- PPU write 0x0102005 data 0x3C with sd_ack delayed 5 cycles → sd_addr/sd_wdata stable throughout; ppu_done one cycle after ack; ppu_rdata unchanged.
- Two cpu_req strobes (0x10, then 0x20) while a PPU read is in flight → only 0x20 issued for CPU; overflow=2'b01.
- Spurious sd_rvalid in IDLE with data 0xFF → no rdata change, no done pulse.
- Reset asserted in WAIT_DATA → sd_req, busy and done all 0 immediately; slots empty; a fresh request after release issues normally.
